// File: rtl/timer_sched_pkg.sv
// timer_sched_pkg: shared types and constants for the timer scheduler.
//   state_e  : scheduler FSM state (IDLE, LOAD, RUN, DONE)
//   TMR_W    : width of the shared timer's count and preset
//   TMR_FULL : uptime terminal count (full scale of the timer)
package timer_sched_pkg;
  localparam int TMR_W = 4;
  localparam logic [TMR_W-1:0] TMR_FULL = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;
endpackage

// File: rtl/timer_sched_if.sv
// timer_sched_if: bundle between requesters/timer (master) and the scheduler (slave).
//   req, req_mode, req_preset : per-requester job request, mode and preset
//   grant, busy, done_pulse   : ownership and completion back to requesters
//   tmr_load/enable/mode/preset : control of the shared timer
//   tmr_done                  : the timer's done flag
// Handshake: req[i] is a level held by requester i until it sees
// done_pulse[i] (one cycle), or dropped earlier to abort its job. grant is
// one-hot and held from the load cycle through the done_pulse cycle.
interface timer_sched_if #(
  parameter int NREQ = 4
);
  import timer_sched_pkg::*;

  logic [NREQ-1:0]       req;
  logic [NREQ-1:0]       req_mode;
  logic [TMR_W*NREQ-1:0] req_preset;
  logic [NREQ-1:0]       grant;
  logic                  busy;
  logic [NREQ-1:0]       done_pulse;
  logic                  tmr_load;
  logic                  tmr_enable;
  logic                  tmr_mode;
  logic [TMR_W-1:0]      tmr_preset;
  logic                  tmr_done;

  modport master (
    output req, req_mode, req_preset, tmr_done,
    input  grant, busy, done_pulse, tmr_load, tmr_enable, tmr_mode, tmr_preset
  );

  modport slave (
    input  req, req_mode, req_preset, tmr_done,
    output grant, busy, done_pulse, tmr_load, tmr_enable, tmr_mode, tmr_preset
  );
endinterface

// File: rtl/timer_4bit.sv
// timer_4bit: 4-bit countdown/uptime timer shared by the scheduler.
//   load/preset : load count from preset and clear done
//   enable      : advance one step; at terminal (0 down, 15 up) set done instead
//   mode        : 1 = count down to 0, 0 = count up to 15
//   count, done : current count and sticky done flag (cleared by load)
module timer_4bit
  import timer_sched_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             enable,
  input  logic             mode,
  input  logic [TMR_W-1:0] preset,
  output logic [TMR_W-1:0] count,
  output logic             done
);
  logic at_end;
  assign at_end = mode ? (count == '0) : (count == TMR_FULL);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      done  <= 1'b0;
    end else if (load) begin
      count <= preset;
      done  <= 1'b0;
    end else if (enable) begin
      if (at_end) done <= 1'b1;
      else        count <= mode ? count - 1'b1 : count + 1'b1;
    end
  end
endmodule

// File: rtl/timer_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   req : request vector
//   ptr : index where the search starts (searches upward modulo NREQ)
//   gnt : one-hot winner (zero if no request)
//   idx : winner index
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx
);
  always_comb begin
    int  j;
    logic found;
    j     = 0;
    found = 1'b0;
    gnt   = '0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr) + k) % NREQ;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end
endmodule

// File: rtl/timer_sched.sv
// timer_sched: round-robin owner of one shared timer_4bit.
//   clk, reset_n : clock and asynchronous active-low reset
//   bus          : slave side of timer_sched_if (requests in, grant/done out,
//                  timer control out, timer done in)
//   dbg_state    : current FSM state
// Every output is registered; they are computed from the next state so they
// line up with the state they belong to.
module timer_sched
  import timer_sched_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int PRESCALE = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  timer_sched_if.slave bus,
  output logic [1:0]   dbg_state
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  state_e            state, state_n;
  logic [IW-1:0]     ptr, owner, win_idx, owner_nxt;
  logic [NREQ-1:0]   win_gnt;
  logic [IW+1:0]     sel_base;
  logic              own_mode;
  logic [TMR_W-1:0]  own_preset;
  logic [PW-1:0]     pc, pc_n;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
    .req (bus.req),
    .ptr (ptr),
    .gnt (win_gnt),
    .idx (win_idx)
  );

  assign sel_base  = {win_idx, 2'b00};
  assign owner_nxt = (owner == IW'(NREQ - 1)) ? '0 : owner + 1'b1;
  assign pc_n      = (pc == PW'(PRESCALE - 1)) ? '0 : pc + 1'b1;
  assign dbg_state = state;

  // Abort is tested before tmr_done so a dropped request wins the tie.
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (|bus.req) state_n = ST_LOAD;
      ST_LOAD: state_n = ST_RUN;
      ST_RUN: begin
        if (!bus.req[owner])   state_n = ST_IDLE;
        else if (bus.tmr_done) state_n = ST_DONE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      ptr            <= '0;
      owner          <= '0;
      own_mode       <= 1'b0;
      own_preset     <= '0;
      pc             <= '0;
      bus.grant      <= '0;
      bus.busy       <= 1'b0;
      bus.done_pulse <= '0;
      bus.tmr_load   <= 1'b0;
      bus.tmr_enable <= 1'b0;
      bus.tmr_mode   <= 1'b0;
      bus.tmr_preset <= '0;
    end else begin
      state          <= state_n;
      bus.tmr_load   <= 1'b0;
      bus.tmr_enable <= 1'b0;
      bus.done_pulse <= '0;
      if (state == ST_DONE || (state == ST_RUN && state_n == ST_IDLE))
        ptr <= owner_nxt;
      case (state_n)
        ST_IDLE: begin
          bus.grant      <= '0;
          bus.busy       <= 1'b0;
          bus.tmr_mode   <= 1'b0;
          bus.tmr_preset <= '0;
        end
        ST_LOAD: begin
          owner          <= win_idx;
          own_mode       <= bus.req_mode[win_idx];
          own_preset     <= bus.req_preset[sel_base +: TMR_W];
          bus.grant      <= win_gnt;
          bus.busy       <= 1'b1;
          bus.tmr_load   <= 1'b1;
          bus.tmr_mode   <= bus.req_mode[win_idx];
          bus.tmr_preset <= bus.req_preset[sel_base +: TMR_W];
          pc             <= '0;
        end
        ST_RUN: begin
          bus.tmr_mode   <= own_mode;
          bus.tmr_preset <= own_preset;
          if (state == ST_LOAD) begin
            pc             <= '0;
            bus.tmr_enable <= (PRESCALE == 1);
          end else begin
            pc             <= pc_n;
            bus.tmr_enable <= (pc_n == PW'(PRESCALE - 1));
          end
        end
        default: begin
          bus.done_pulse <= bus.grant;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_timer_sched.sv
module tb_timer_sched;
  import timer_sched_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] dbg1, dbg3;
  logic [3:0] cnt1, cnt3;
  int         checks = 0;
  int         failures = 0;
  logic [15:0] exp_q[$];
  logic [3:0]  gnt_q[$];

  timer_sched_if #(.NREQ(4)) bus1 ();
  timer_sched_if #(.NREQ(4)) bus3 ();

  timer_sched #(.NREQ(4), .PRESCALE(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1), .dbg_state(dbg1)
  );
  timer_sched #(.NREQ(4), .PRESCALE(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .bus(bus3), .dbg_state(dbg3)
  );

  timer_4bit tmr1 (
    .clk(clk), .reset(~reset_n), .load(bus1.tmr_load), .enable(bus1.tmr_enable),
    .mode(bus1.tmr_mode), .preset(bus1.tmr_preset), .count(cnt1), .done(bus1.tmr_done)
  );
  timer_4bit tmr3 (
    .clk(clk), .reset(~reset_n), .load(bus3.tmr_load), .enable(bus3.tmr_enable),
    .mode(bus3.tmr_mode), .preset(bus3.tmr_preset), .count(cnt3), .done(bus3.tmr_done)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    bus1.req = '0; bus1.req_mode = '0; bus1.req_preset = '0;
    bus3.req = '0; bus3.req_mode = '0; bus3.req_preset = '0;
  endtask

  task automatic do_reset;
    reset_n = 1'b0;
    clear_inputs();
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  // scenarios
  task automatic test_reset;
    reset_n = 1'b0;
    clear_inputs();
    tick();
    checks++;
    if ({bus1.grant, bus1.busy, bus1.done_pulse, bus1.tmr_load, bus1.tmr_enable,
         bus1.tmr_mode, bus1.tmr_preset, dbg1} !== 19'd0) begin
      failures++;
      $display("FAIL reset_dut1: got grant=%b busy=%b done=%b load=%b en=%b mode=%b preset=%h state=%0d, want all 0",
               bus1.grant, bus1.busy, bus1.done_pulse, bus1.tmr_load, bus1.tmr_enable,
               bus1.tmr_mode, bus1.tmr_preset, dbg1);
    end
    checks++;
    if ({bus3.grant, bus3.busy, bus3.done_pulse, bus3.tmr_load, bus3.tmr_enable,
         bus3.tmr_mode, bus3.tmr_preset, dbg3} !== 19'd0) begin
      failures++;
      $display("FAIL reset_dut3: got grant=%b busy=%b done=%b load=%b en=%b state=%0d, want all 0",
               bus3.grant, bus3.busy, bus3.done_pulse, bus3.tmr_load, bus3.tmr_enable, dbg3);
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_countdown;
    int c;
    logic [15:0] e;
    do_reset();
    bus1.req_mode[0] = 1'b1;
    bus1.req_preset[3:0] = 4'd5;
    bus1.req[0] = 1'b1;
    exp_q.push_back({8'd9, 8'h01});
    c = 0;
    while (c < 14) begin
      tick(); c++;
      if (c == 1) begin
        checks++;
        if ({bus1.grant, bus1.busy, bus1.tmr_load, bus1.tmr_mode, bus1.tmr_preset} !== {4'b0001, 1'b1, 1'b1, 1'b1, 4'd5}) begin
          failures++;
          $display("FAIL cd_load: got grant=%b busy=%b load=%b mode=%b preset=%h, want 0001 1 1 1 5",
                   bus1.grant, bus1.busy, bus1.tmr_load, bus1.tmr_mode, bus1.tmr_preset);
        end
        // latched job must ignore later input changes
        bus1.req_mode[0] = 1'b0;
        bus1.req_preset[3:0] = 4'd0;
      end
      if (c == 2) begin
        checks++;
        if ({bus1.tmr_load, bus1.tmr_enable, bus1.tmr_mode, dbg1} !== {1'b0, 1'b1, 1'b1, ST_RUN}) begin
          failures++;
          $display("FAIL cd_run: got load=%b en=%b mode=%b state=%0d, want 0 1 1 2",
                   bus1.tmr_load, bus1.tmr_enable, bus1.tmr_mode, dbg1);
        end
      end
      if (bus1.done_pulse !== 4'b0) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL cd_done: unexpected done_pulse=%b at cycle %0d", bus1.done_pulse, c);
        end else begin
          e = exp_q.pop_front();
          if ({8'(c), 4'b0, bus1.done_pulse} !== e) begin
            failures++;
            $display("FAIL cd_done: got cycle=%0d bits=%b, want cycle=%0d bits=%b", c, bus1.done_pulse, e[15:8], e[3:0]);
          end
        end
        bus1.req[0] = 1'b0;
      end
      if (c == 10) begin
        checks++;
        if ({bus1.grant, bus1.busy} !== 5'b0) begin
          failures++;
          $display("FAIL cd_clear: got grant=%b busy=%b in cycle 10, want 0 0", bus1.grant, bus1.busy);
        end
      end
    end
    if (exp_q.size() != 0) begin
      checks++; failures++;
      $display("FAIL cd_timeout: %0d done_pulse(s) never seen", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_uptime_prescale;
    int c;
    logic [15:0] e;
    logic want_en;
    do_reset();
    bus3.req_mode[2] = 1'b0;
    bus3.req_preset[11:8] = 4'd13;
    bus3.req[2] = 1'b1;
    exp_q.push_back({8'd12, 8'h04});
    c = 0;
    while (c < 16) begin
      tick(); c++;
      if (c == 1) begin
        checks++;
        if ({bus3.grant, bus3.tmr_load, bus3.tmr_mode, bus3.tmr_preset} !== {4'b0100, 1'b1, 1'b0, 4'd13}) begin
          failures++;
          $display("FAIL up_load: got grant=%b load=%b mode=%b preset=%h, want 0100 1 0 d",
                   bus3.grant, bus3.tmr_load, bus3.tmr_mode, bus3.tmr_preset);
        end
      end
      if (c >= 2 && c <= 12) begin
        want_en = (c == 4 || c == 7 || c == 10);
        checks++;
        if (bus3.tmr_enable !== want_en) begin
          failures++;
          $display("FAIL up_enable: cycle %0d got tmr_enable=%b, want %b", c, bus3.tmr_enable, want_en);
        end
      end
      if (bus3.done_pulse !== 4'b0) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL up_done: unexpected done_pulse=%b at cycle %0d", bus3.done_pulse, c);
        end else begin
          e = exp_q.pop_front();
          if ({8'(c), 4'b0, bus3.done_pulse} !== e) begin
            failures++;
            $display("FAIL up_done: got cycle=%0d bits=%b, want cycle=%0d bits=%b", c, bus3.done_pulse, e[15:8], e[3:0]);
          end
        end
        bus3.req[2] = 1'b0;
      end
    end
    if (exp_q.size() != 0) begin
      checks++; failures++;
      $display("FAIL up_timeout: %0d done_pulse(s) never seen", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_fairness;
    int c, loads, last_done;
    logic [15:0] e;
    logic [3:0] g;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      bus1.req_mode[i] = 1'b1;
      bus1.req_preset[4*i +: 4] = 4'd1;
    end
    gnt_q.delete();
    gnt_q.push_back(4'b0001); gnt_q.push_back(4'b0010); gnt_q.push_back(4'b0100);
    gnt_q.push_back(4'b1000); gnt_q.push_back(4'b0001);
    bus1.req = 4'hF;
    c = 0; loads = 0; last_done = -10;
    while (c < 60 && loads < 5) begin
      tick(); c++;
      if (bus1.tmr_load === 1'b1) begin
        g = gnt_q.pop_front();
        loads++;
        checks++;
        if (bus1.grant !== g) begin
          failures++;
          $display("FAIL rr_grant: load %0d got grant=%b, want %b", loads, bus1.grant, g);
        end
        // preset 1 countdown: done_pulse 4 cycles after the load cycle
        if (loads < 5) exp_q.push_back({8'(c + 4), 4'b0, g});
        else bus1.req = 4'h0;
      end
      if (c == last_done + 1) begin
        checks++;
        if ({bus1.grant, bus1.busy} !== 5'b0) begin
          failures++;
          $display("FAIL rr_gap: cycle %0d after done got grant=%b busy=%b, want idle", c, bus1.grant, bus1.busy);
        end
      end
      if (bus1.done_pulse !== 4'b0) begin
        checks++;
        last_done = c;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL rr_done: unexpected done_pulse=%b at cycle %0d", bus1.done_pulse, c);
        end else begin
          e = exp_q.pop_front();
          if ({8'(c), 4'b0, bus1.done_pulse} !== e) begin
            failures++;
            $display("FAIL rr_done: got cycle=%0d bits=%b, want cycle=%0d bits=%b", c, bus1.done_pulse, e[15:8], e[3:0]);
          end
        end
      end
    end
    if (loads < 5) begin
      checks++; failures++;
      $display("FAIL rr_timeout: only %0d of 5 grants seen", loads);
    end
    for (int k = 0; k < 6; k++) begin
      tick();
      if (bus1.done_pulse !== 4'b0) begin
        checks++; failures++;
        $display("FAIL rr_abort_done: got done_pulse=%b after dropping requests, want 0000", bus1.done_pulse);
      end
    end
    if (exp_q.size() != 0) begin
      checks++; failures++;
      $display("FAIL rr_missing: %0d done_pulse(s) never seen", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_abort;
    int c;
    logic [15:0] e;
    do_reset();
    bus1.req_mode[0] = 1'b1; bus1.req_preset[3:0] = 4'd9;
    bus1.req_mode[1] = 1'b1; bus1.req_preset[7:4] = 4'd9;
    bus1.req[0] = 1'b1; bus1.req[1] = 1'b1;
    c = 0;
    while (c < 30) begin
      tick(); c++;
      if (c == 1) begin
        checks++;
        if (bus1.grant !== 4'b0001) begin
          failures++;
          $display("FAIL ab_grant0: got grant=%b, want 0001", bus1.grant);
        end
      end
      if (c == 4) bus1.req[0] = 1'b0;
      if (c == 5) begin
        checks++;
        if ({bus1.grant, bus1.busy, bus1.done_pulse} !== 9'd0) begin
          failures++;
          $display("FAIL ab_clear: got grant=%b busy=%b done=%b, want all 0", bus1.grant, bus1.busy, bus1.done_pulse);
        end
        // with ptr advanced to 1, requester 1 must still beat requester 0
        bus1.req[0] = 1'b1;
      end
      if (c == 6) begin
        checks++;
        if ({bus1.grant, bus1.tmr_load} !== {4'b0010, 1'b1}) begin
          failures++;
          $display("FAIL ab_next: got grant=%b load=%b, want 0010 1", bus1.grant, bus1.tmr_load);
        end
        exp_q.push_back({8'd18, 8'h02});
      end
      if (bus1.done_pulse !== 4'b0) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL ab_done: unexpected done_pulse=%b at cycle %0d", bus1.done_pulse, c);
        end else begin
          e = exp_q.pop_front();
          if ({8'(c), 4'b0, bus1.done_pulse} !== e) begin
            failures++;
            $display("FAIL ab_done: got cycle=%0d bits=%b, want cycle=%0d bits=%b", c, bus1.done_pulse, e[15:8], e[3:0]);
          end
        end
        bus1.req = 4'h0;
        c = 30;
      end
    end
    if (exp_q.size() != 0) begin
      checks++; failures++;
      $display("FAIL ab_timeout: %0d done_pulse(s) never seen", exp_q.size());
      exp_q.delete();
    end
    tick();
  endtask

  // Runs right after test_abort without reset, so the timer still holds a
  // done flag from the previous completed job.
  task automatic test_boundary;
    int   b_idx[3]  = '{2, 3, 0};
    logic b_mode[3] = '{1'b1, 1'b0, 1'b1};
    int   b_pre[3]  = '{0, 15, 3};
    int c, n;
    logic [15:0] e;
    logic [3:0] oh;
    for (int t = 0; t < 3; t++) begin
      oh = 4'b0001 << b_idx[t];
      n  = b_mode[t] ? b_pre[t] : 15 - b_pre[t];
      bus1.req_mode[b_idx[t]] = b_mode[t];
      bus1.req_preset[4*b_idx[t] +: 4] = 4'(b_pre[t]);
      bus1.req[b_idx[t]] = 1'b1;
      exp_q.push_back({8'(n + 4), 4'b0, oh});
      c = 0;
      while (c < 25) begin
        tick(); c++;
        if (bus1.done_pulse !== 4'b0) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL bd_done: unexpected done_pulse=%b at cycle %0d", bus1.done_pulse, c);
          end else begin
            e = exp_q.pop_front();
            if ({8'(c), 4'b0, bus1.done_pulse} !== e) begin
              failures++;
              $display("FAIL bd_done: job %0d got cycle=%0d bits=%b, want cycle=%0d bits=%b",
                       t, c, bus1.done_pulse, e[15:8], e[3:0]);
            end
          end
          bus1.req = 4'h0;
          c = 25;
        end
      end
      if (exp_q.size() != 0) begin
        checks++; failures++;
        $display("FAIL bd_timeout: job %0d done_pulse never seen", t);
        exp_q.delete();
        bus1.req = 4'h0;
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_run;
    int c;
    do_reset();
    bus1.req_mode[2] = 1'b1; bus1.req_preset[11:8] = 4'd9;
    bus1.req[2] = 1'b1;
    c = 0;
    while (c < 5) begin
      tick(); c++;
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({bus1.grant, bus1.busy, bus1.done_pulse, bus1.tmr_load, bus1.tmr_enable,
         bus1.tmr_mode, bus1.tmr_preset, dbg1} !== 19'd0) begin
      failures++;
      $display("FAIL rst_mid: got grant=%b busy=%b load=%b en=%b mode=%b preset=%h state=%0d, want all 0",
               bus1.grant, bus1.busy, bus1.tmr_load, bus1.tmr_enable, bus1.tmr_mode, bus1.tmr_preset, dbg1);
    end
    bus1.req = 4'h0;
    tick();
    reset_n = 1'b1;
    tick();
    // ptr must be back at 0: requester 1 beats requester 3
    bus1.req_mode[1] = 1'b1; bus1.req_preset[7:4] = 4'd4;
    bus1.req_mode[3] = 1'b1; bus1.req_preset[15:12] = 4'd4;
    bus1.req[1] = 1'b1; bus1.req[3] = 1'b1;
    tick();
    checks++;
    if ({bus1.grant, bus1.tmr_load, bus1.tmr_preset} !== {4'b0010, 1'b1, 4'd4}) begin
      failures++;
      $display("FAIL rst_ptr: got grant=%b load=%b preset=%h, want 0010 1 4",
               bus1.grant, bus1.tmr_load, bus1.tmr_preset);
    end
    bus1.req = 4'h0;
    for (int k = 0; k < 4; k++) tick();
    checks++;
    if ({bus1.grant, bus1.busy} !== 5'b0) begin
      failures++;
      $display("FAIL rst_abort: got grant=%b busy=%b after dropping requests, want 0 0", bus1.grant, bus1.busy);
    end
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_uptime_prescale();
    test_fairness();
    test_abort();
    test_boundary();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
